rf_wport_arbiter: RTL



---
 rtl/rf_arb_pkg.sv | 10 +
 rtl/rf_arb_fifo.sv | 35 +++
 rtl/rf_wport_arbiter.sv | 74 +++++++
 3 files changed

// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared types and widths for the regfile write-port arbiter.
package rf_arb_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;
  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [XLEN-1:0]   wd;
  } entry_t;
endpackage

// File: rtl/rf_arb_fifo.sv
// rf_arb_fifo: synchronous DEPTH-entry FIFO holding pending secondary writes.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  entry_t      din,
  output entry_t      head,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);
  entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign head  = mem[rd_ptr];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the regfile write port between core writeback and a buffered secondary writer.
// Define RF_ARB_STALL_EN to add the starvation counter, FORCE state and stall output.
module rf_wport_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int MAX_WAIT = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_write,
  input  logic [REG_AW-1:0] wb_wa,
  input  logic [XLEN-1:0]   wb_wd,
  input  logic              sec_valid,
  output logic              sec_ready,
  input  logic [REG_AW-1:0] sec_wa,
  input  logic [XLEN-1:0]   sec_wd,
  output logic              stall,
  output logic              rf_write,
  output logic [REG_AW-1:0] rf_wa,
  output logic [XLEN-1:0]   rf_wd,
  output logic [CW-1:0]     pend_count
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : g_bad_param
    $error("rf_wport_arbiter: illegal DEPTH or MAX_WAIT");
  end
  logic busy, push, pop, full, empty;
  entry_t din, head;
  assign busy      = wb_write && wb_wa != '0;
  assign sec_ready = !rst && !full;
  assign push      = sec_valid && sec_ready && sec_wa != '0;
  assign pop       = !rst && !busy && !empty;
  assign din       = '{wa: sec_wa, wd: sec_wd};
  assign rf_write  = !rst && (busy || !empty);
  assign rf_wa     = busy ? wb_wa : head.wa;
  assign rf_wd     = busy ? wb_wd : head.wd;
  rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (din),
    .head (head),
    .count(pend_count),
    .full (full),
    .empty(empty)
  );
`ifdef RF_ARB_STALL_EN
  localparam int WW = $clog2(MAX_WAIT) + 1;
  state_t state, state_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic drained;
  assign drained = (pend_count + CW'(push) - CW'(pop)) == '0;
  // WAIT without a pop means the head lost its slot to the core
  always_comb begin
    state_n = drained ? IDLE
            : (state == WAIT && !pop && wait_cnt == WW'(MAX_WAIT - 1)) ? FORCE : WAIT;
    wait_n  = (state == WAIT && state_n == WAIT && !pop) ? wait_cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
    end
  end
  assign stall = !rst && state == FORCE;
`else
  assign stall = 1'b0;
`endif
endmodule
